fm_sb_freeze_seq: RTL

- Parametrised successor to the spy-buffer freeze/playback control. Drives per-channel freeze and playback-mode for SB_N spy buffers from global software controls plus per-channel masks.
- Adds a sequencer on top of the masking: arm, external trigger, programmable post-trigger delay, release, and timed spy-memory initialisation.
- Sits between the FM AXI control registers and the spy-buffer array, in the axi_clk domain.

---
 rtl/fm_sb_pkg.sv | 21 ++
 rtl/fm_sb_mask_apply.sv | 30 +++
 rtl/fm_sb_freeze_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fm_sb_pkg.sv
// Shared types and defaults for the spy-buffer freeze/playback sequencer.
package fm_sb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    POST_TRIG = 3'd2,
    FROZEN    = 3'd3,
    INIT      = 3'd4
  } fm_sb_seq_state_t;

  localparam int unsigned PB_MODE_WIDTH       = 2;
  localparam int unsigned INIT_CYCLES_DEFAULT = 1024;
  localparam int unsigned EVT_CNT_W           = 16;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fm_sb_mask_apply.sv
// Per-channel registered masking: each channel outputs 0 when masked, else the shared value.
module fm_sb_mask_apply #(
  parameter int unsigned SB_N = 96,
  parameter int unsigned DW   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        value,
  input  logic [SB_N-1:0]      mask,
  output logic [SB_N*DW-1:0]   out_q
);

  logic [SB_N*DW-1:0] out_d;

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < SB_N; i++) begin
      out_d[i*DW +: DW] = mask[i] ? '0 : value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/fm_sb_freeze_seq.sv
// Spy-buffer freeze/playback sequencer: arm, trigger, post-trigger delay, release, timed init.
// Optional freeze event counter enabled by defining FM_SB_FREEZE_CNT_EN.
module fm_sb_freeze_seq
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_N        = 96,
  parameter int unsigned PB_MODE_W   = PB_MODE_WIDTH,
  parameter int unsigned POST_W      = 16,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEFAULT
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  global_freeze,
  input  logic [PB_MODE_W-1:0]  global_pb_mode,
  input  logic [SB_N-1:0]       freeze_mask,
  input  logic [SB_N-1:0]       playback_mask,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  ext_trigger,
  input  logic                  release_req,
  input  logic                  init_req,
  input  logic [POST_W-1:0]     post_trig_len,
  output logic [SB_N-1:0]       freeze,
  output logic [PB_MODE_W-1:0]  playback_mode [SB_N],
  output logic                  init_spy_mem,
  output fm_sb_seq_state_t      state,
  output logic [POST_W-1:0]     post_cnt,
  output logic [EVT_CNT_W-1:0]  freeze_evt_cnt
);

  localparam int unsigned INIT_CNT_W = cnt_width(INIT_CYCLES);
  localparam logic [INIT_CNT_W-1:0] INIT_LOAD = INIT_CNT_W'(INIT_CYCLES - 1);

  fm_sb_seq_state_t        state_q, state_d;
  logic [POST_W-1:0]       post_cnt_q, post_cnt_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PB_MODE_W-1:0]    pb_mode_q, pb_mode_d;
  logic                    init_spy_mem_q, init_spy_mem_d;

  logic                    frz_val;
  logic [PB_MODE_W-1:0]    pb_val;
  logic [SB_N*PB_MODE_W-1:0] pb_flat;

  // Sequencer next-state; init counter holds INIT for exactly INIT_CYCLES cycles.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d    = INIT;
          init_cnt_d = INIT_LOAD;
        end else if (global_freeze) begin
          state_d = FROZEN;
        end else if (arm) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (global_freeze) begin
          state_d = FROZEN;
        end else if (ext_trigger) begin
          if (post_trig_len == '0) begin
            state_d = FROZEN;
          end else begin
            state_d    = POST_TRIG;
            post_cnt_d = post_trig_len;
          end
        end else if (disarm) begin
          state_d = IDLE;
        end
      end
      POST_TRIG: begin
        if (global_freeze || (post_cnt_q <= POST_W'(1))) begin
          state_d    = FROZEN;
          post_cnt_d = '0;
        end else begin
          post_cnt_d = post_cnt_q - POST_W'(1);
        end
      end
      FROZEN: begin
        if (init_req) begin
          state_d    = INIT;
          init_cnt_d = INIT_LOAD;
        end else if (release_req && !global_freeze) begin
          state_d = IDLE;
        end
      end
      INIT: begin
        if (init_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          init_cnt_d = init_cnt_q - INIT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Playback mode is only sampled while the buffers are idle or frozen.
  always_comb begin
    pb_mode_d      = pb_mode_q;
    init_spy_mem_d = (state_q == INIT);
    if ((state_q == IDLE) || (state_q == FROZEN)) begin
      pb_mode_d = global_pb_mode;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q        <= IDLE;
      post_cnt_q     <= '0;
      init_cnt_q     <= '0;
      pb_mode_q      <= '0;
      init_spy_mem_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      post_cnt_q     <= post_cnt_d;
      init_cnt_q     <= init_cnt_d;
      pb_mode_q      <= pb_mode_d;
      init_spy_mem_q <= init_spy_mem_d;
    end
  end

  assign frz_val = (state_q == FROZEN);
  assign pb_val  = (state_q == INIT) ? '0 : pb_mode_q;

  fm_sb_mask_apply #(
    .SB_N (SB_N),
    .DW   (1)
  ) u_freeze_mask (
    .clk   (axi_clk),
    .rst   (axi_reset),
    .value (frz_val),
    .mask  (freeze_mask),
    .out_q (freeze)
  );

  fm_sb_mask_apply #(
    .SB_N (SB_N),
    .DW   (PB_MODE_W)
  ) u_pb_mask (
    .clk   (axi_clk),
    .rst   (axi_reset),
    .value (pb_val),
    .mask  (playback_mask),
    .out_q (pb_flat)
  );

  for (genvar i = 0; i < SB_N; i++) begin : g_pb
    assign playback_mode[i] = pb_flat[i*PB_MODE_W +: PB_MODE_W];
  end

  assign init_spy_mem = init_spy_mem_q;
  assign state        = state_q;
  assign post_cnt     = post_cnt_q;

`ifdef FM_SB_FREEZE_CNT_EN
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  // Count FROZEN entries, saturating; an INIT entry wipes the history.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if ((state_d == INIT) && (state_q != INIT)) begin
      evt_cnt_d = '0;
    end else if ((state_d == FROZEN) && (state_q != FROZEN) && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign freeze_evt_cnt = evt_cnt_q;
`else
  assign freeze_evt_cnt = '0;
`endif

endmodule
